// File: rtl/button_chord_if.sv
// ============================================================================
// button_chord_if : key inputs and chord-code outputs of the button front end
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface button_chord_if;
    logic [3:0] keys_n;
    logic [3:0] button_code;
    logic [3:0] key_state;
    logic       busy;

    modport master (input keys_n, output button_code, key_state, busy);
    modport slave  (output keys_n, input button_code, key_state, busy);
endinterface

`default_nettype wire

// File: rtl/button_chord_encoder.sv
// ============================================================================
// button_chord_encoder : sync + debounce four keys, emit one OR-chord per gesture
// Revision             : 1.0
// ============================================================================
`default_nettype none

module button_chord_encoder #(
    parameter int DEBOUNCE_CYCLES = 480,
    parameter int HOLD_TIMEOUT    = 96000
) (
    input  wire logic      clk_48,
    input  wire logic      reset_n,
    button_chord_if.master bus
);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHORD  = 2'd1,
        ST_CANCEL = 2'd2
    } state_t;

    logic [3:0]        sync_meta;
    logic [3:0]        sync_ff;
    logic [3:0]        sync;
    logic [3:0]        key_state_r;
    state_t            state;
    logic [3:0]        chord;
    logic [3:0]        code_r;
    logic [HOLD_W-1:0] hold_cnt;
    logic              busy_r;

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '1;
            sync_ff   <= '1;
        end else begin
            sync_meta <= bus.keys_n;
            sync_ff   <= sync_meta;
        end
    end

    assign sync = ~sync_ff;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_debounce
            logic [DEB_W-1:0] cnt;
            logic             stable;

            // Any agreeing sample restarts the run, so short glitches never flip.
            always_ff @(posedge clk_48 or negedge reset_n) begin
                if (!reset_n) begin
                    cnt    <= '0;
                    stable <= 1'b0;
                end else if (sync[i] == stable) begin
                    cnt <= '0;
                end else if (cnt == DEB_LAST) begin
                    cnt    <= '0;
                    stable <= ~stable;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign key_state_r[i] = stable;
        end
    endgenerate

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            chord    <= '0;
            code_r   <= '0;
            hold_cnt <= '0;
            busy_r   <= 1'b0;
        end else begin
            code_r <= '0;
            case (state)
                ST_IDLE: begin
                    if (key_state_r != 4'b0000) begin
                        state    <= ST_CHORD;
                        chord    <= key_state_r;
                        hold_cnt <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                ST_CHORD: begin
                    // Release is tested before the timeout so a coincident release still emits.
                    if (key_state_r == 4'b0000) begin
                        state  <= ST_IDLE;
                        code_r <= chord;
                        chord  <= '0;
                        busy_r <= 1'b0;
                    end else if ((HOLD_TIMEOUT != 0) && (hold_cnt == HOLD_LAST)) begin
                        state <= ST_CANCEL;
                        chord <= '0;
                    end else begin
                        chord <= chord | key_state_r;
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_CANCEL: begin
                    if (key_state_r == 4'b0000) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    chord  <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.button_code = code_r;
    assign bus.key_state   = key_state_r;
    assign bus.busy        = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_button_chord_encoder.sv
// ============================================================================
// tb_button_chord_encoder : directed + random stimulus against a gesture-level model
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_button_chord_encoder;
    localparam int D  = 4;
    localparam int HT = 50;

    logic clk_48;
    logic reset_n;
    button_chord_if bus ();

    button_chord_encoder #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_TIMEOUT   (HT)
    ) dut (
        .clk_48 (clk_48),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulses = 0;
    logic [3:0] last_code = 4'b0000;
    logic [3:0] ks_seen   = 4'b0000;

    // Reference model: raw sample history plus a gesture record
    logic [3:0] rawq[$];
    logic [3:0] m_ks;
    logic [3:0] m_code;
    logic [3:0] m_acc;
    logic       m_busy;
    logic       m_active;
    logic       m_cancel;
    int         m_held;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rawq.delete();
        for (int j = 0; j < D + 1; j++) rawq.push_back(4'hF);
        m_ks = 4'b0000; m_code = 4'b0000; m_acc = 4'b0000;
        m_busy = 1'b0; m_active = 1'b0; m_cancel = 1'b0; m_held = 0;
    endtask

    task automatic model_step();
        logic flip;
        m_code = 4'b0000;
        if (!m_active) begin
            if (m_ks != 4'b0000) begin
                m_active = 1'b1; m_cancel = 1'b0; m_acc = m_ks; m_held = 1;
            end
        end else if (m_ks == 4'b0000) begin
            if (!m_cancel) m_code = m_acc;
            m_active = 1'b0;
        end else if (!m_cancel) begin
            m_held++;
            m_acc = m_acc | m_ks;
            if (HT != 0 && m_held > HT) m_cancel = 1'b1;
        end
        m_busy = m_active;
        // A key flips once its last D synchronised samples (raw delayed two cycles) all disagree.
        rawq.push_back(bus.keys_n);
        if (rawq.size() > D + 2) void'(rawq.pop_front());
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++) begin
                if ((!rawq[j][i]) == m_ks[i]) flip = 1'b0;
            end
            if (flip) m_ks[i] = ~m_ks[i];
        end
    endtask

    always @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clk_48) begin
        chk("key_state", bus.key_state, m_ks);
        chk("busy", {3'b000, bus.busy}, {3'b000, m_busy});
        chk("button_code", bus.button_code, m_code);
        if (bus.button_code != 4'b0000) begin
            n_pulses++;
            last_code = bus.button_code;
        end
        ks_seen = ks_seen | bus.key_state;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_48);
        #1;
    endtask

    initial begin
        int lat;
        int p0;
        int r;
        model_reset();
        reset_n    = 1'b0;
        bus.keys_n = 4'hF;
        cycles(2);
        chk("reset_code", bus.button_code, 4'b0000);
        chk("reset_ks", bus.key_state, 4'b0000);
        reset_n = 1'b1;
        cycles(3);

        // Single press: latency of debounce and of emission
        p0 = n_pulses;
        bus.keys_n = 4'b1110;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_48); #1;
            if (lat < 0 && bus.key_state[0]) lat = i;
        end
        chk_int("press_latency", lat, 6);
        chk("busy_hold", {3'b000, bus.busy}, 4'b0001);
        bus.keys_n = 4'hF;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_48); #1;
            if (lat < 0 && bus.button_code != 4'b0000) lat = i;
        end
        chk_int("release_latency", lat, 7);
        chk("single_code", last_code, 4'b0001);
        chk_int("single_pulses", n_pulses - p0, 1);
        chk("single_busy_after", {3'b000, bus.busy}, 4'b0000);

        // Bounce on key1
        p0 = n_pulses;
        ks_seen = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            bus.keys_n = bus.keys_n ^ 4'b0010;
            cycles(2);
        end
        chk("bounce_ks", ks_seen, 4'b0000);
        bus.keys_n = 4'b1101;
        cycles(20);
        bus.keys_n = 4'hF;
        cycles(20);
        chk_int("bounce_pulses", n_pulses - p0, 1);
        chk("bounce_code", last_code, 4'b0010);

        // Staggered chord; final release lands exactly on the timeout edge
        p0 = n_pulses;
        bus.keys_n = 4'b1110; cycles(10);
        bus.keys_n = 4'b1100; cycles(10);
        bus.keys_n = 4'b1000; cycles(10);
        bus.keys_n = 4'b1001; cycles(10);
        bus.keys_n = 4'b1011; cycles(10);
        bus.keys_n = 4'b1111; cycles(20);
        chk_int("chord_pulses", n_pulses - p0, 1);
        chk("chord_code", last_code, 4'b0111);

        // Timeout then a fresh gesture
        p0 = n_pulses;
        bus.keys_n = 4'b0111;
        cycles(65);
        chk("cancel_busy", {3'b000, bus.busy}, 4'b0001);
        cycles(5);
        bus.keys_n = 4'hF;
        cycles(20);
        chk_int("timeout_pulses", n_pulses - p0, 0);
        chk("timeout_busy_after", {3'b000, bus.busy}, 4'b0000);
        bus.keys_n = 4'b0111; cycles(15);
        bus.keys_n = 4'hF;    cycles(20);
        chk_int("retry_pulses", n_pulses - p0, 1);
        chk("retry_code", last_code, 4'b1000);

        // Reset in the middle of a held chord
        p0 = n_pulses;
        bus.keys_n = 4'b1100;
        cycles(20);
        chk("pre_reset_ks", bus.key_state, 4'b0011);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_code", bus.button_code, 4'b0000);
        chk("rst_ks", bus.key_state, 4'b0000);
        chk("rst_busy", {3'b000, bus.busy}, 4'b0000);
        bus.keys_n = 4'hF;
        cycles(3);
        reset_n = 1'b1;
        cycles(30);
        chk_int("reset_pulses", n_pulses - p0, 0);

        // Glitch shorter than sync plus debounce
        p0 = n_pulses;
        ks_seen = 4'b0000;
        bus.keys_n = 4'b1011; cycles(3);
        bus.keys_n = 4'hF;    cycles(20);
        chk("glitch_ks", ks_seen, 4'b0000);
        chk_int("glitch_pulses", n_pulses - p0, 0);
        chk("glitch_busy", {3'b000, bus.busy}, 4'b0000);

        // Random key activity, occasionally long enough to time out
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r < 3) bus.keys_n = 4'hF;
            else       bus.keys_n = 4'($urandom);
            cycles((r == 9) ? $urandom_range(40, 70) : $urandom_range(1, 12));
        end
        bus.keys_n = 4'hF;
        cycles(30);
        chk("final_busy", {3'b000, bus.busy}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
